fb_spi_loader: RTL

SPI-slave framebuffer loader that fills the 256×32-bit BRAM read by the VGA scan-out stage. An external host streams a write command, a start word address and pixel data over SPI mode 0. The block packs the bytes into 32-bit words and issues one-cycle BRAM write strobes. It sits directly upstream of the scan-out: it drives the BRAM write port, and the scan-out owns the read port.

---
 rtl/fb_spi_loader_if.sv | 25 ++
 rtl/fb_spi_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fb_spi_loader_if.sv
// SPI pins plus BRAM write port and status of the framebuffer loader.
// The master modport is the loader's view; slave is the host/BRAM/scan-out side.
interface fb_spi_loader_if #(
  parameter int ADDR_W = 8
);
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              bram_wr_en;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [31:0]       bram_wr_data;
  logic              busy;
  logic              frame_done;
  logic              cmd_err;

  modport master (
    input  spi_sck, spi_cs_n, spi_mosi,
    output bram_wr_en, bram_wr_addr, bram_wr_data, busy, frame_done, cmd_err
  );

  modport slave (
    output spi_sck, spi_cs_n, spi_mosi,
    input  bram_wr_en, bram_wr_addr, bram_wr_data, busy, frame_done, cmd_err
  );
endinterface

// File: rtl/fb_spi_loader.sv
// SPI mode-0 slave that receives a write command, a start word address and
// pixel bytes, packs them little-endian into 32-bit words and strobes them
// into the framebuffer BRAM write port.
module fb_spi_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] CMD_WRITE = 8'h02
) (
  input  logic           clk,
  input  logic           rst_n,
  fb_spi_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  // Pin order in the synchroniser vector: {sck, cs_n, mosi}. CS resets to
  // its deasserted level so reset release never looks like a CS edge.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0] w_pins;
  logic [2:0] w_sync;

  assign w_pins = {bus.spi_sck, bus.spi_cs_n, bus.spi_mosi};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic r_s1;
      logic r_s2;
      // Two-flop synchroniser bringing one SPI pin into the clk domain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1 <= SYNC_RST[gi];
          r_s2 <= SYNC_RST[gi];
        end else begin
          r_s1 <= w_pins[gi];
          r_s2 <= r_s1;
        end
      end
      assign w_sync[gi] = r_s2;
    end
  endgenerate

  logic w_sck, w_cs_n, w_mosi;
  assign w_sck  = w_sync[2];
  assign w_cs_n = w_sync[1];
  assign w_mosi = w_sync[0];

  state_t            r_state, w_state_next;
  logic              r_sck_d, r_cs_d;
  logic [2:0]        r_bit_cnt, w_bit_next;
  logic [7:0]        r_shift, w_shift_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [1:0]        r_lane, w_lane_next;
  logic [23:0]       r_word, w_word_next;
  logic              r_committed, w_committed_next;
  logic              r_wr_en, w_wr_en_next;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next;
  logic [31:0]       r_wr_data, w_wr_data_next;
  logic              r_frame_done, w_frame_done_next;
  logic              r_cmd_err, w_cmd_err_next;

  logic       w_sck_rise, w_cs_fall, w_cs_rise;
  logic       w_shift_en, w_byte_done;
  logic [7:0] w_byte;

  assign w_sck_rise  = w_sck & ~r_sck_d;
  assign w_cs_fall   = ~w_cs_n & r_cs_d;
  assign w_cs_rise   = w_cs_n & ~r_cs_d;
  // SCK is only meaningful while receiving; IDLE and IGNORE discard it.
  assign w_shift_en  = w_sck_rise & ~w_cs_n &
                       ((r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA));
  assign w_byte_done = w_shift_en && (r_bit_cnt == 3'd7);
  assign w_byte      = {r_shift[6:0], w_mosi};

  // Next-state, datapath and one-cycle pulse decode; cs_rise overrides a coincident byte
  always_comb begin
    w_state_next      = r_state;
    w_bit_next        = r_bit_cnt;
    w_shift_next      = r_shift;
    w_addr_next       = r_addr;
    w_lane_next       = r_lane;
    w_word_next       = r_word;
    w_committed_next  = r_committed;
    w_wr_en_next      = 1'b0;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_frame_done_next = 1'b0;
    w_cmd_err_next    = 1'b0;

    if (w_cs_rise) begin
      // Any partial word is dropped simply by resetting the lane.
      w_frame_done_next = (r_state == S_DATA) && r_committed;
      w_state_next      = S_IDLE;
      w_lane_next       = 2'd0;
      w_bit_next        = 3'd0;
      w_committed_next  = 1'b0;
    end else begin
      if (w_shift_en) begin
        w_shift_next = w_byte;
        w_bit_next   = r_bit_cnt + 3'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            w_state_next     = S_CMD;
            w_bit_next       = 3'd0;
            w_lane_next      = 2'd0;
            w_committed_next = 1'b0;
          end
        end
        S_CMD: begin
          if (w_byte_done) begin
            if (w_byte == CMD_WRITE) begin
              w_state_next = S_ADDR;
            end else begin
              w_state_next   = S_IGNORE;
              w_cmd_err_next = 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (w_byte_done) begin
            w_addr_next  = w_byte[ADDR_W-1:0];
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (w_byte_done) begin
            case (r_lane)
              2'd0: w_word_next[7:0]   = w_byte;
              2'd1: w_word_next[15:8]  = w_byte;
              2'd2: w_word_next[23:16] = w_byte;
              default: begin
                w_wr_en_next     = 1'b1;
                w_wr_addr_next   = r_addr;
                w_wr_data_next   = {w_byte, r_word};
                w_addr_next      = r_addr + 1'b1;
                w_committed_next = 1'b1;
              end
            endcase
            w_lane_next = r_lane + 2'd1;
          end
        end
        default: begin
          // IGNORE: wait for CS to rise.
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any burst without a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sck_d      <= 1'b0;
      r_cs_d       <= 1'b1;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'd0;
      r_addr       <= '0;
      r_lane       <= 2'd0;
      r_word       <= 24'd0;
      r_committed  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= 32'd0;
      r_frame_done <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sck_d      <= w_sck;
      r_cs_d       <= w_cs_n;
      r_bit_cnt    <= w_bit_next;
      r_shift      <= w_shift_next;
      r_addr       <= w_addr_next;
      r_lane       <= w_lane_next;
      r_word       <= w_word_next;
      r_committed  <= w_committed_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_frame_done <= w_frame_done_next;
      r_cmd_err    <= w_cmd_err_next;
    end
  end

  assign bus.bram_wr_en   = r_wr_en;
  assign bus.bram_wr_addr = r_wr_addr;
  assign bus.bram_wr_data = r_wr_data;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.frame_done   = r_frame_done;
  assign bus.cmd_err      = r_cmd_err;

endmodule
